rr_arbiter_16: RTL and testbench

Round-robin arbiter sharing one resource among 16 requesters. It scans a 16-bit request vector, picks the next requester after the previous owner, and holds the grant until that requester drops its request. The grant is kept internally as a 4-bit owner index and decoded into a one-hot grant vector, the same index-to-line function as the lab's 4-to-16 decoder. Sits between requesting lab modules and a shared bus, memory port or display driver.

---
 rtl/rr_arbiter_16.sv | 118 +++++++++++
 tb/tb_rr_arbiter_16.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter: 16 requesters, grant held until released.
// Optional hold-time limit enabled by defining RR_TIMEOUT_EN.
module rr_arbiter_16 #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] owner, owner_n;
  logic [IDX_W-1:0] pick;
  logic             found;

`ifdef RR_TIMEOUT_EN
  logic [7:0] hold_cnt, hold_n;
  logic       to_q, to_n;
`else
  logic [7:0] unused_max_hold;
  assign unused_max_hold = 8'(MAX_HOLD);
`endif

  // First set request at or after ptr, wrapping modulo N
  always_comb begin
    logic [IDX_W-1:0] cand;
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
`ifdef RR_TIMEOUT_EN
    hold_n  = hold_cnt;
    to_n    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          owner_n = pick;
          ptr_n   = pick + 1'b1;
          state_n = GRANT;
`ifdef RR_TIMEOUT_EN
          hold_n  = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          state_n = IDLE;
        end
`ifdef RR_TIMEOUT_EN
        else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          state_n = IDLE;
          to_n    = 1'b1;
        end else begin
          hold_n = hold_cnt + 8'd1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
`ifdef RR_TIMEOUT_EN
      hold_cnt <= 8'd0;
      to_q     <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      owner    <= owner_n;
`ifdef RR_TIMEOUT_EN
      hold_cnt <= hold_n;
      to_q     <= to_n;
`endif
    end
  end

  // Outputs decode flops only; owner is masked so idle reads as 0
  assign grant_valid = (state == GRANT);
  assign grant_idx   = grant_valid ? owner : '0;
  assign grant       = grant_valid ? (N'(1) << owner) : '0;

`ifdef RR_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed vector bench for rr_arbiter_16.
// Table rows are applied one clock each; timeout corner is hand-sequenced.
module tb_rr_arbiter_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] g;
    logic [3:0]  idx;
    logic        to;
  } vec_t;

  vec_t tbl[$];

  rr_arbiter_16 dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [15:0] q,
                     input logic [15:0] g, input logic [3:0] ix);
    vec_t v;
    v.rst = r;
    v.req = q;
    v.g   = g;
    v.idx = ix;
    v.to  = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic [15:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] g,
                     input logic [3:0] ix, input logic to);
    logic [21:0] act, exp;
    act = {grant, grant_idx, grant_valid, timeout};
    exp = {g, ix, (g != 16'h0), to};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got grant=%h idx=%0d valid=%b to=%b, want grant=%h idx=%0d valid=%b to=%b",
               nm, grant, grant_idx, grant_valid, timeout,
               g, ix, (g != 16'h0), to);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 16'hFFFF;

    // reset with all requesting
    add(1, 16'hFFFF, 16'h0000, 0);
    add(1, 16'hFFFF, 16'h0000, 0);
    add(0, 16'hFFFF, 16'h0001, 0);
    add(0, 16'h0000, 16'h0000, 0);
    // single requester 5
    add(0, 16'h0020, 16'h0020, 5);
    add(0, 16'h0020, 16'h0020, 5);
    add(0, 16'h0000, 16'h0000, 0);
    add(0, 16'h0000, 16'h0000, 0);
    // rotation between 0 and 15
    add(1, 16'h0000, 16'h0000, 0);
    add(0, 16'h8001, 16'h0001, 0);
    add(0, 16'h8001, 16'h0001, 0);
    add(0, 16'h8001, 16'h0001, 0);
    add(0, 16'h8000, 16'h0000, 0);
    add(0, 16'h8001, 16'h8000, 15);
    add(0, 16'h8001, 16'h8000, 15);
    add(0, 16'h8001, 16'h8000, 15);
    add(0, 16'h0001, 16'h0000, 0);
    add(0, 16'h8001, 16'h0001, 0);
    // wrap-around after owner 15
    add(0, 16'h8000, 16'h0000, 0);
    add(0, 16'h8000, 16'h8000, 15);
    add(0, 16'h0006, 16'h0000, 0);
    add(0, 16'h0006, 16'h0002, 1);
    // no preemption by other bits
    add(0, 16'hFFFE, 16'h0002, 1);
    add(0, 16'h0000, 16'h0000, 0);
    // reset mid-grant
    add(0, 16'h0100, 16'h0100, 8);
    add(1, 16'h0100, 16'h0000, 0);
    add(0, 16'h0101, 16'h0001, 0);
    add(0, 16'h0000, 16'h0000, 0);
    // lone requester re-granted after idle
    add(0, 16'h0001, 16'h0001, 0);
    add(0, 16'h0000, 16'h0000, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req);
      chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].idx, tbl[i].to);
    end

    // hold-limit sequence with two requesters
    step(1, 16'h0000);
    chk("to_rst", 16'h0000, 0, 0);
    for (int c = 0; c < 8; c++) begin
      step(0, 16'h0003);
      chk($sformatf("to_hold%0d", c), 16'h0001, 0, 0);
    end
`ifdef RR_TIMEOUT_EN
    step(0, 16'h0003);
    chk("to_pulse", 16'h0000, 0, 1);
    step(0, 16'h0003);
    chk("to_next", 16'h0002, 1, 0);
    for (int c = 0; c < 7; c++) begin
      step(0, 16'h0003);
      chk($sformatf("to_hold1_%0d", c), 16'h0002, 1, 0);
    end
    // release on the limit edge wins over revocation
    step(0, 16'h0001);
    chk("to_rel_wins", 16'h0000, 0, 0);
    step(0, 16'h0001);
    chk("to_after_rel", 16'h0001, 0, 0);
`else
    for (int c = 0; c < 12; c++) begin
      step(0, 16'h0003);
      chk($sformatf("no_to%0d", c), 16'h0001, 0, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
